// File: rtl/rx_fct_send.sv
// -----------------------------------------------------------------------------
// rx_fct_send
//
// Receive-side flow-control credit manager for a link that grants N-char
// credit in fixed-size FCT blocks. The block tracks how many N-chars the
// link partner may still send, asks the transmitter for another FCT whenever
// both the credit window and the receive FIFO have room for another block,
// and flags any N-char that arrives without credit.
//
// Parameters
//   CREDIT_MAX  maximum outstanding N-char credit (multiple of 8, <= 56)
//   FCT_WEIGHT  N-chars granted by each transmitted FCT
//
// Ports
//   pclk_rx       in   1  receive-side clock, all state on rising edge
//   enable_rx     in   1  asynchronous active-low reset
//   got_nchar     in   1  one-cycle pulse per received N-char
//   fifo_free     in   7  receive FIFO free entries, 0..64
//   fct_sent      in   1  TX acknowledge, level, high once the FCT went out
//   send_fct      out  1  registered request to TX for one FCT
//   credit_rx     out  6  N-chars granted but not yet received
//   credit_error  out  1  sticky flag: N-char received with zero credit
// -----------------------------------------------------------------------------
module rx_fct_send #(
  parameter int CREDIT_MAX = 56,
  parameter int FCT_WEIGHT = 8
) (
  input  logic       pclk_rx,
  input  logic       enable_rx,
  input  logic       got_nchar,
  input  logic [6:0] fifo_free,
  input  logic       fct_sent,
  output logic       send_fct,
  output logic [5:0] credit_rx,
  output logic       credit_error
);

  // Three-bit encoding so that the unused codes 3..7 are representable and
  // can be steered back to IDLE.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_LOW = 3'd2
  } state_t;

  // Comparisons are done at 8 bits so credit + weight can never wrap.
  localparam logic [7:0] WEIGHT_W = 8'(FCT_WEIGHT);
  localparam logic [7:0] LIMIT_W  = 8'(CREDIT_MAX - FCT_WEIGHT);
  localparam logic [5:0] WEIGHT_6 = 6'(FCT_WEIGHT);

  state_t     state_r;
  state_t     state_s;
  logic       send_fct_r;
  logic       send_fct_s;
  logic [5:0] credit_r;
  logic [5:0] credit_s;
  logic       err_r;
  logic       err_s;
  logic       room_s;
  logic       add_s;

  // True when one more FCT fits both in the credit window and in the FIFO.
  function automatic logic fct_room(input logic [5:0] credit,
                                    input logic [6:0] free);
    logic [7:0] credit_ext;
    logic [7:0] free_ext;
    credit_ext = {2'b00, credit};
    free_ext   = {1'b0, free};
    return (credit_ext <= LIMIT_W) && (free_ext >= credit_ext + WEIGHT_W);
  endfunction

  assign room_s = fct_room(credit_r, fifo_free);

  // Next-state logic for the FCT request handshake.
  always_comb begin
    state_s = state_r;
    add_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (room_s) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // The acknowledge both closes the request and grants the credit;
        // WAIT_LOW then swallows the rest of a long acknowledge.
        if (fct_sent) begin
          state_s = WAIT_LOW;
          add_s   = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      WAIT_LOW: begin
        if (fct_sent) begin
          state_s = WAIT_LOW;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request output: high for every cycle spent in REQ after the entry edge,
  // dropped on the same edge the acknowledge is taken.
  always_comb begin
    send_fct_s = 1'b0;
    if (state_r == REQ) begin
      send_fct_s = ~fct_sent;
    end else begin
      send_fct_s = 1'b0;
    end
  end

  // Credit accounting: consume on N-char, grant on acknowledge, flag
  // underflow. A consume at zero credit is dropped, so the counter never
  // wraps, and a same-edge grant still lands in full.
  always_comb begin
    credit_s = credit_r;
    err_s    = err_r;
    if (got_nchar) begin
      if (credit_r != 6'd0) begin
        credit_s = credit_r - 6'd1;
      end else begin
        err_s = 1'b1;
      end
    end else begin
      credit_s = credit_r;
    end
    if (add_s) begin
      credit_s = credit_s + WEIGHT_6;
    end else begin
      credit_s = credit_s;
    end
  end

  // State, request and credit registers; reset acts without a clock edge.
  always_ff @(posedge pclk_rx or negedge enable_rx) begin
    if (!enable_rx) begin
      state_r    <= IDLE;
      send_fct_r <= 1'b0;
      credit_r   <= 6'd0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      send_fct_r <= send_fct_s;
      credit_r   <= credit_s;
      err_r      <= err_s;
    end
  end

  assign send_fct     = send_fct_r;
  assign credit_rx    = credit_r;
  assign credit_error = err_r;

endmodule

// File: tb/tb_rx_fct_send.sv
// -----------------------------------------------------------------------------
// tb_rx_fct_send
//
// Directed bench for rx_fct_send. A protocol-level model (credit as a plain
// integer, request/acknowledge as open/waiting flags) predicts the outputs,
// and a compare process checks them every falling clock edge. Hand-computed
// literal expectations pin the model at the end of each scenario.
// -----------------------------------------------------------------------------
module tb_rx_fct_send;

  localparam int CMAX = 56;
  localparam int W    = 8;

  logic       pclk_rx   = 1'b0;
  logic       enable_rx = 1'b1;
  logic       got_nchar = 1'b0;
  logic [6:0] fifo_free = 7'd0;
  logic       fct_sent  = 1'b0;
  logic       send_fct;
  logic [5:0] credit_rx;
  logic       credit_error;

  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;
  int   rise_cnt = 0;
  logic send_prev = 1'b0;

  rx_fct_send #(.CREDIT_MAX(CMAX), .FCT_WEIGHT(W)) dut (
    .pclk_rx      (pclk_rx),
    .enable_rx    (enable_rx),
    .got_nchar    (got_nchar),
    .fifo_free    (fifo_free),
    .fct_sent     (fct_sent),
    .send_fct     (send_fct),
    .credit_rx    (credit_rx),
    .credit_error (credit_error)
  );

  always #5 pclk_rx = ~pclk_rx;

  // Protocol model: open = an FCT has been decided and not yet acknowledged,
  // show = request visible to TX, hold = acknowledged, waiting for it to end.
  typedef struct packed {
    int credit;
    bit err;
    bit open;
    bit show;
    bit hold;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(mstate_t s, bit got, bit ack, int free);
    mstate_t n = s;
    int delta = 0;
    if (s.open && ack) begin
      delta  = W;
      n.open = 1'b0;
      n.show = 1'b0;
      n.hold = 1'b1;
    end else if (s.open) begin
      n.show = 1'b1;
    end else if (s.hold) begin
      if (!ack) n.hold = 1'b0;
    end else if (s.credit <= CMAX - W && free >= s.credit + W) begin
      n.open = 1'b1;
    end
    if (got) begin
      if (s.credit > 0) delta = delta - 1;
      else n.err = 1'b1;
    end
    n.credit = s.credit + delta;
    return n;
  endfunction

  always @(posedge pclk_rx or negedge enable_rx) begin
    if (!enable_rx) m <= '0;
    else m <= model_step(m, got_nchar, fct_sent, int'(fifo_free));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, plus request edge counting.
  always @(negedge pclk_rx) begin
    if (cmp_en) begin
      chk("cyc_send_fct", int'(send_fct), int'(m.show));
      chk("cyc_credit_rx", int'(credit_rx), m.credit);
      chk("cyc_credit_error", int'(credit_error), int'(m.err));
    end
    send_prev <= send_fct;
    if (send_fct === 1'b1 && send_prev !== 1'b1) rise_cnt <= rise_cnt + 1;
  end

  task automatic tick();
    @(negedge pclk_rx);
    #1;
  endtask

  task automatic do_reset(input int free);
    enable_rx = 1'b0;
    fct_sent  = 1'b0;
    got_nchar = 1'b0;
    fifo_free = 7'(free);
    tick();
    tick();
    chk("rst_send_fct", int'(send_fct), 0);
    chk("rst_credit_rx", int'(credit_rx), 0);
    chk("rst_credit_error", int'(credit_error), 0);
    enable_rx = 1'b1;
  endtask

  task automatic wait_send(input string name);
    int n = 0;
    while (send_fct !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (send_fct !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_send_timeout actual=0 expected=1", name);
    end
  endtask

  task automatic ack_pulse(input string name, input int len);
    wait_send(name);
    fct_sent = 1'b1;
    repeat (len) tick();
    fct_sent = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    #1 enable_rx = 1'b0;
    #1 cmp_en = 1'b1;

    // Fill the window from zero with single-cycle acknowledges.
    do_reset(64);
    r0 = rise_cnt;
    for (int k = 1; k <= 7; k++) begin
      ack_pulse("s28", 1);
      chk("s28_credit_step", int'(credit_rx), 8 * k);
    end
    repeat (10) tick();
    chk("s28_send_stays_low", int'(send_fct), 0);
    chk("s28_request_count", rise_cnt - r0, 7);
    chk("s28_credit_full", int'(credit_rx), 56);

    // Drain one block from a full window, then refill it.
    got_nchar = 1'b1;
    repeat (8) tick();
    got_nchar = 1'b0;
    chk("s29_credit_drained", int'(credit_rx), 48);
    ack_pulse("s29", 1);
    chk("s29_credit_refilled", int'(credit_rx), 56);

    // FIFO room limits the grant to a single block.
    do_reset(10);
    ack_pulse("s30", 1);
    chk("s30_credit_one_block", int'(credit_rx), 8);
    repeat (10) tick();
    chk("s30_no_second_req", int'(send_fct), 0);
    chk("s30_credit_hold", int'(credit_rx), 8);

    // N-char with no credit: sticky error, counter does not wrap.
    do_reset(0);
    got_nchar = 1'b1;
    tick();
    got_nchar = 1'b0;
    chk("s31_error_set", int'(credit_error), 1);
    chk("s31_credit_no_wrap", int'(credit_rx), 0);
    fifo_free = 7'd64;
    ack_pulse("s31a", 1);
    ack_pulse("s31b", 1);
    chk("s31_error_sticky", int'(credit_error), 1);
    chk("s31_credit_after", int'(credit_rx), 16);
    do_reset(0);

    // Grant and N-char on the same edge at zero credit.
    do_reset(64);
    wait_send("s20");
    fct_sent  = 1'b1;
    got_nchar = 1'b1;
    tick();
    got_nchar = 1'b0;
    fct_sent  = 1'b0;
    tick();
    chk("s20_credit", int'(credit_rx), 8);
    chk("s20_error", int'(credit_error), 1);

    // Long acknowledge with a same-edge N-char at credit 8.
    do_reset(64);
    ack_pulse("s32a", 1);
    wait_send("s32b");
    fct_sent  = 1'b1;
    got_nchar = 1'b1;
    tick();
    got_nchar = 1'b0;
    repeat (4) tick();
    fct_sent = 1'b0;
    tick();
    chk("s32_credit_single_add", int'(credit_rx), 15);
    chk("s32_no_error", int'(credit_error), 0);

    // Reset in the middle of a request; stale acknowledge afterwards.
    do_reset(64);
    ack_pulse("s33a", 1);
    wait_send("s33b");
    #2 enable_rx = 1'b0;
    #1;
    chk("s33_async_send", int'(send_fct), 0);
    chk("s33_async_credit", int'(credit_rx), 0);
    fct_sent  = 1'b1;
    fifo_free = 7'd0;
    tick();
    enable_rx = 1'b1;
    repeat (3) tick();
    chk("s33_stale_ack_credit", int'(credit_rx), 0);
    chk("s33_stale_ack_send", int'(send_fct), 0);
    fct_sent  = 1'b0;
    fifo_free = 7'd64;
    ack_pulse("s33c", 1);
    chk("s33_fresh_grant", int'(credit_rx), 8);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_fct_send.md
RX_FCT_SEND -- requirements
Module: rx_fct_send

Interface
REQ-001 The block SHALL have parameter CREDIT_MAX, default 56, giving the maximum outstanding N-char credit (multiple of 8, at most 56).
REQ-002 The block SHALL have parameter FCT_WEIGHT, default 8, giving the N-chars granted per transmitted FCT.
REQ-003 The block SHALL have port pclk_rx  input  1  receive-side clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port enable_rx  input  1  reset; asynchronous, active-low (low = reset).
REQ-005 The block SHALL have port got_nchar  input  1  one-cycle pulse per N-char (data, EOP or EEP) received from the link partner.
REQ-006 The block SHALL have port fifo_free  input  7  receive FIFO free entries, 0..64.
REQ-007 The block SHALL have port fct_sent  input  1  TX-side level acknowledge; high for one or more cycles once the requested FCT has gone out.
REQ-008 The block SHALL have port send_fct  output  1  request to TX to transmit one FCT.
REQ-009 The block SHALL have port credit_rx  output  6  N-chars the partner may still send (granted but not yet received).
REQ-010 The block SHALL have port credit_error  output  1  sticky credit violation flag.

Function
REQ-011 The FSM SHALL have three states: IDLE (0), REQ (1), WAIT_LOW (2); encodings 3..7 SHALL return to IDLE on the next cycle.
REQ-012 IDLE SHALL go to REQ when both hold: credit_rx <= CREDIT_MAX - FCT_WEIGHT, and fifo_free >= credit_rx + FCT_WEIGHT, both evaluated on the current registered values.
REQ-013 send_fct SHALL be a registered output: 1 in the cycle after entering REQ, and held 1 for the whole time in REQ.
REQ-014 In REQ, fct_sent = 1 SHALL cause, in the same edge: send_fct to go 0, credit_rx to gain FCT_WEIGHT, and a transition to WAIT_LOW.
REQ-015 WAIT_LOW SHALL stay while fct_sent = 1 and go to IDLE when fct_sent = 0; no credit is added in WAIT_LOW.
REQ-016 Each fct_sent high period SHALL add exactly one FCT_WEIGHT, regardless of how long it lasts; fct_sent outside REQ SHALL be ignored.
REQ-017 got_nchar = 1 with credit_rx > 0 SHALL decrement credit_rx by 1, in any state.
REQ-018 got_nchar = 1 with credit_rx = 0 (pre-edge value) SHALL set credit_error to 1; credit_rx SHALL NOT wrap below 0.
REQ-019 Simultaneous credit add (REQ-014) and got_nchar SHALL produce a net change of FCT_WEIGHT - 1 when pre-edge credit_rx > 0.
REQ-020 Simultaneous credit add and got_nchar with pre-edge credit_rx = 0 SHALL set credit_error and leave credit_rx = FCT_WEIGHT.
REQ-021 credit_rx SHALL never exceed CREDIT_MAX, since REQ-012 blocks any request that would overflow it; no saturation logic is required.
REQ-022 credit_error, once set, SHALL stay 1 until reset and SHALL NOT stop counting or FCT requests.
REQ-023 The minimum latency from the IDLE request condition becoming true to send_fct = 1 SHALL be 2 cycles: one edge to enter REQ, one registered output edge.
REQ-024 Back-to-back FCTs SHALL be separated by at least one IDLE cycle.

Reset
REQ-025 enable_rx = 0 SHALL immediately, without waiting for a clock edge, force: state = IDLE, send_fct = 0, credit_rx = 0, credit_error = 0.
REQ-026 Reset asserted in REQ or WAIT_LOW SHALL abandon the handshake; after release, any fct_sent still high SHALL be ignored until the block re-enters REQ.
REQ-027 After reset release, the first request SHALL follow REQ-012, starting from credit_rx = 0.

Verification
REQ-028 Scenario: release reset with fifo_free = 64 and fct_sent pulsed 1 cycle per request -> send_fct rises 7 times and credit_rx steps 8, 16 ... 56, then send_fct stays 0.
REQ-029 Scenario: at credit_rx = 56, apply 8 got_nchar pulses with fifo_free = 64 -> credit_rx = 48, one new request, credit_rx = 56 after fct_sent.
REQ-030 Scenario: fifo_free = 10, credit_rx = 0 -> one FCT (credit_rx = 8); no second request, because 10 < 16.
REQ-031 Scenario: credit_rx = 0, single got_nchar -> credit_error = 1, credit_rx = 0; error stays 1 through later FCTs until enable_rx = 0.
REQ-032 Scenario: fct_sent held high 5 cycles in REQ together with one got_nchar at credit_rx = 8 -> credit_rx = 15; no double add.
REQ-033 Scenario: enable_rx dropped mid-REQ -> send_fct = 0 and credit_rx = 0 asynchronously; fct_sent still high after release adds no credit.
